// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } div_state_e;

  // Bit of the control-unit sign code that selects signed division.
  localparam int unsigned SignSigned = 1;

  // Default datapath width. DivLat counts clocks from the edge that starts
  // driving start to the edge after which done is visible.
  localparam int unsigned DivWidth = 32;
  localparam int unsigned DivLat   = DivWidth + 2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, and shift in the resulting quotient bit.
module div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rem,
  input  logic [Width-1:0] quo,
  input  logic [Width-1:0] dvs,
  output logic [Width-1:0] rem_next,
  output logic [Width-1:0] quo_next
);

  logic [Width:0] rem_shift;
  logic           ge;

  // Compare at Width+1 bits so the bit shifted out of rem is not lost.
  always_comb begin
    rem_shift = {rem, quo[Width-1]};
    ge        = (rem_shift >= {1'b0, dvs});
    // The true difference is always below dvs, so the low Width bits suffice.
    rem_next  = ge ? (rem_shift[Width-1:0] - dvs) : rem_shift[Width-1:0];
    quo_next  = {quo[Width-2:0], ge};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: latches operands, runs one quotient bit per
// clock, applies the sign fix-up and loads the HI/LO result registers.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       sign,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [Width-1:0] hi,
  output logic [Width-1:0] lo
);

  div_state_e       state_q, state_d;
  logic [Width-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             dvs_zero_q, dvs_zero_d, dbz_q, dbz_d;
  logic [Width-1:0] rem_step, quo_step;
  logic             is_signed, dvd_neg, dvs_neg;
  logic             unused_sign0;

  assign unused_sign0 = sign[0];

  div_step #(
    .Width(Width)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_next(rem_step),
    .quo_next(quo_step)
  );

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dvs_zero_d = dvs_zero_q;
    dbz_d      = dbz_q;
    is_signed  = sign[SignSigned];
    dvd_neg    = is_signed & dividend[Width-1];
    dvs_neg    = is_signed & divisor[Width-1];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          quo_d      = dvd_neg ? -dividend : dividend;
          dvs_d      = dvs_neg ? -divisor : divisor;
          rem_d      = '0;
          q_neg_d    = dvd_neg ^ dvs_neg;
          r_neg_d    = dvd_neg;
          dvs_zero_d = (divisor == '0);
          cnt_d      = CntW'(Width);
          state_d    = StRun;
        end
      end
      StRun: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // With a zero divisor every bit of |dividend| ends up in rem, so the
        // normal remainder fix-up already reproduces the original dividend.
        hi_d    = r_neg_q ? -rem_q : rem_q;
        lo_d    = dvs_zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        dbz_d   = dvs_zero_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dvs_zero_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dvs_zero_q <= dvs_zero_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl.
module tb_div_seq_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  sign;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int lat, busy_n, cnt;

  div_seq_ctrl #(
    .Width(32),
    .CntW (6)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .sign       (sign),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an operation from an idle cycle (called #1 after an edge) and waits
  // for done. Extra start pulses fire after edges p1/p2. Returns in the done
  // cycle; lat is 0 if done never came.
  task automatic do_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                       input int p1, input int p2, output int lat_o, output int busy_o);
    sign     = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat_o    = 0;
    busy_o   = 0;
    for (int k = 1; k <= int'(DivLat) + 6; k++) begin
      @(posedge clk);
      #1;
      start = (k == p1) || (k == p2);
      if (k == 1) begin
        // Scramble inputs: the DUT must have latched them.
        sign     = ~s;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
      end
      if (busy) busy_o++;
      if (done) begin
        lat_o = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    sign     = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    idle_edge();

    // 1: unsigned 7/2
    do_op(2'b00, 32'd7, 32'd2, 0, 0, lat, busy_n);
    check_eq("t1_lat", lat, DivLat);
    check_eq("t1_busy_cycles", busy_n, 32'd33);
    check_eq("t1_lo", lo, 32'd3);
    check_eq("t1_hi", hi, 32'd1);
    check_eq("t1_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) idle_edge();
    check_eq("t1_lo_hold", lo, 32'd3);
    check_eq("t1_hi_hold", hi, 32'd1);

    // 2: signed -7/2
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, busy_n);
    check_eq("t2_lat", lat, DivLat);
    check_eq("t2_lo", lo, 32'hFFFF_FFFD);
    check_eq("t2_hi", hi, 32'hFFFF_FFFF);
    idle_edge();

    // 3: 0xFFFFFFFF/16 unsigned, then signed (-1/16); sign[0] must not matter
    do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0010, 0, 0, lat, busy_n);
    check_eq("t3u_lat", lat, DivLat);
    check_eq("t3u_lo", lo, 32'h0FFF_FFFF);
    check_eq("t3u_hi", hi, 32'h0000_000F);
    idle_edge();
    do_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 0, 0, lat, busy_n);
    check_eq("t3s_lat", lat, DivLat);
    check_eq("t3s_lo", lo, 32'd0);
    check_eq("t3s_hi", hi, 32'hFFFF_FFFF);
    idle_edge();

    // 4: signed 100/0, then a valid op clears the flag at its done
    do_op(2'b10, 32'd100, 32'd0, 0, 0, lat, busy_n);
    check_eq("t4_lat", lat, DivLat);
    check_eq("t4_lo", lo, 32'hFFFF_FFFF);
    check_eq("t4_hi", hi, 32'd100);
    check_eq("t4_dbz", {31'd0, div_by_zero}, 32'd1);
    idle_edge();
    do_op(2'b00, 32'd100, 32'd9, 0, 0, lat, busy_n);
    check_eq("t4n_lat", lat, DivLat);
    check_eq("t4n_lo", lo, 32'd11);
    check_eq("t4n_hi", hi, 32'd1);
    check_eq("t4n_dbz", {31'd0, div_by_zero}, 32'd0);

    // 5: start pulses mid-op ignored; start in DONE ignored; next cycle accepted
    idle_edge();
    do_op(2'b00, 32'd1000, 32'd7, 5, 20, lat, busy_n);
    check_eq("t5_lat", lat, DivLat);
    check_eq("t5_lo", lo, 32'd142);
    check_eq("t5_hi", hi, 32'd6);
    start = 1'b1;                      // sampled while in DONE
    idle_edge();
    start = 1'b0;
    check_eq("t5_done_start_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_done_start_done", {31'd0, done}, 32'd0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, busy_n);
    check_eq("t5o_lat", lat, DivLat);
    check_eq("t5o_lo", lo, 32'h8000_0000);
    check_eq("t5o_hi", hi, 32'd0);
    check_eq("t5o_dbz", {31'd0, div_by_zero}, 32'd0);
    idle_edge();

    // 6: async reset mid-run discards the op
    sign     = 2'b00;
    dividend = 32'd50;
    divisor  = 32'd3;
    start    = 1'b1;
    idle_edge();
    start = 1'b0;
    repeat (9) idle_edge();
    check_eq("t6_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_done", {31'd0, done}, 32'd0);
    check_eq("t6_dbz", {31'd0, div_by_zero}, 32'd0);
    check_eq("t6_hi", hi, 32'd0);
    check_eq("t6_lo", lo, 32'd0);
    repeat (2) idle_edge();
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      idle_edge();
      if (done || busy) cnt++;
    end
    check_eq("t6_no_done", cnt, 32'd0);
    do_op(2'b00, 32'd100, 32'd7, 0, 0, lat, busy_n);
    check_eq("t6n_lat", lat, DivLat);
    check_eq("t6n_lo", lo, 32'd14);
    check_eq("t6n_hi", hi, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
